// File: rtl/replacement_set_controller.sv
// Replacement-state controller: per-set valid bits and age permutations (LRU or FIFO),
// victim selection on miss with invalid-way preference, and line invalidation.
module replacement_set_controller #(
  parameter int N_WAYS  = 4,
  parameter int N_SETS  = 16,
  parameter int POLICY  = 0,
  localparam int BW_WAYS = $clog2(N_WAYS),
  localparam int BW_SETS = (N_SETS > 1) ? $clog2(N_SETS) : 1
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               enable_i,
  input  logic [BW_SETS-1:0] set_i,
  input  logic [BW_WAYS-1:0] way_i,
  input  logic               hit_i,
  input  logic               miss_i,
  input  logic               inval_i,
  output logic               done_o,
  output logic [BW_WAYS-1:0] way_o,
  output logic               evict_valid_o,
  output logic               err_o
);

  localparam logic [BW_WAYS-1:0] AGE_MAX = BW_WAYS'(N_WAYS - 1);
  localparam logic [BW_WAYS-1:0] AGE_ONE = BW_WAYS'(1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_MISS} state_t;

  state_t                                     state;
  logic [N_SETS-1:0][N_WAYS-1:0]              valid;
  logic [N_SETS-1:0][N_WAYS-1:0][BW_WAYS-1:0] age;
  logic [BW_SETS-1:0]                         miss_set;

  logic [BW_SETS-1:0]               op_set;
  logic [N_WAYS-1:0][BW_WAYS-1:0]   cur_age, new_age;
  logic [N_WAYS-1:0]                cur_valid, new_valid;
  logic                             accept, do_inval, do_miss, do_hit, do_fill, wr_set;
  logic [BW_WAYS-1:0]               ref_way, ref_age, inv_way, lru_way;
  logic                             any_inv;

  // The fill cycle addresses the set latched at the miss, not whatever set_i shows now.
  always_comb begin
    op_set    = (state == ST_MISS) ? miss_set : set_i;
    cur_age   = age[op_set];
    cur_valid = valid[op_set];
    accept    = enable_i && (state == ST_IDLE);
    do_inval  = accept && inval_i;
    do_miss   = accept && miss_i && !inval_i;
    do_hit    = accept && hit_i && !inval_i && !miss_i;
    do_fill   = (state == ST_MISS);
    wr_set    = do_fill || do_inval || do_hit;
    ref_way   = do_fill ? way_o : way_i;
    ref_age   = cur_age[ref_way];
  end

  always_comb begin
    inv_way = '0;
    lru_way = '0;
    any_inv = 1'b0;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!cur_valid[w]) begin
        inv_way = BW_WAYS'(w);
        any_inv = 1'b1;
      end
      if (cur_age[w] == AGE_MAX) lru_way = BW_WAYS'(w);
    end
  end

  // Promote moves ref to MRU; demote moves ref to LRU. Both keep ages a permutation.
  always_comb begin
    new_age   = cur_age;
    new_valid = cur_valid;
    for (int w = 0; w < N_WAYS; w++) begin
      if (do_fill || (do_hit && POLICY == 0)) begin
        if (BW_WAYS'(w) == ref_way)    new_age[w] = '0;
        else if (cur_age[w] < ref_age) new_age[w] = cur_age[w] + AGE_ONE;
      end else if (do_inval) begin
        if (BW_WAYS'(w) == ref_way)    new_age[w] = AGE_MAX;
        else if (cur_age[w] > ref_age) new_age[w] = cur_age[w] - AGE_ONE;
      end
    end
    if (do_fill)  new_valid[way_o] = 1'b1;
    if (do_inval) new_valid[way_i] = 1'b0;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state         <= ST_INIT;
      done_o        <= 1'b0;
      way_o         <= '0;
      evict_valid_o <= 1'b0;
      err_o         <= 1'b0;
      miss_set      <= '0;
      valid         <= '0;
      for (int s = 0; s < N_SETS; s++)
        for (int w = 0; w < N_WAYS; w++)
          age[s][w] <= BW_WAYS'(w);
    end else begin
      err_o <= 1'b0;
      case (state)
        ST_INIT: begin
          state  <= ST_IDLE;
          done_o <= 1'b1;
        end
        ST_IDLE: begin
          if (do_miss) begin
            way_o         <= any_inv ? inv_way : lru_way;
            evict_valid_o <= !any_inv;
            done_o        <= 1'b0;
            miss_set      <= set_i;
            state         <= ST_MISS;
          end
          if (do_hit) err_o <= !cur_valid[way_i];
        end
        ST_MISS: begin
          done_o <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
      if (wr_set) begin
        age[op_set]   <= new_age;
        valid[op_set] <= new_valid;
      end
    end
  end

endmodule

// File: tb/tb_replacement_set_controller.sv
// Scoreboard bench: an LRU instance and a FIFO instance share strobes but have separate enables.
module tb_replacement_set_controller;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] en;
  logic [1:0] set;
  logic [1:0] way;
  logic       hit, miss, inval;
  logic [1:0]      done, ev, err;
  logic [1:0][1:0] wayo;

  int checks = 0;
  int errors = 0;

  typedef struct { int w; int e; } miss_t;
  miss_t mq[2][$];
  int    pend_err[2];

  always #5 clk = ~clk;

  replacement_set_controller #(.N_WAYS(4), .N_SETS(4), .POLICY(0)) u_lru (
    .clock_i(clk), .resetn_i(rstn), .enable_i(en[0]), .set_i(set), .way_i(way),
    .hit_i(hit), .miss_i(miss), .inval_i(inval), .done_o(done[0]), .way_o(wayo[0]),
    .evict_valid_o(ev[0]), .err_o(err[0]));

  replacement_set_controller #(.N_WAYS(4), .N_SETS(4), .POLICY(1)) u_fifo (
    .clock_i(clk), .resetn_i(rstn), .enable_i(en[1]), .set_i(set), .way_i(way),
    .hit_i(hit), .miss_i(miss), .inval_i(inval), .done_o(done[1]), .way_o(wayo[1]),
    .evict_valid_o(ev[1]), .err_o(err[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: a falling done_o announces a victim; err_o pulses consume expected errors.
  for (genvar d = 0; d < 2; d++) begin : g_mon
    bit    prev_done = 1'b0;
    int    low = 0;
    miss_t e;
    always @(negedge clk) begin
      if (!rstn) begin
        prev_done = 1'b0;
        low = 0;
      end else begin
        if (!done[d] && prev_done) begin
          if (mq[d].size() == 0) chk($sformatf("unexpected_miss%0d", d), 1, 0);
          else begin
            e = mq[d].pop_front();
            chk($sformatf("victim_way%0d", d), int'(wayo[d]), e.w);
            chk($sformatf("evict_valid%0d", d), int'(ev[d]), e.e);
          end
        end
        if (!done[d]) low++;
        else if (low > 0) begin
          chk($sformatf("done_low_cycles%0d", d), low, 1);
          low = 0;
        end
        if (err[d]) begin
          chk($sformatf("err_expected%0d", d), int'(pend_err[d] > 0), 1);
          if (pend_err[d] > 0) pend_err[d]--;
        end
        prev_done = done[d];
      end
    end
  end

  task automatic idle();
    en = '0; hit = 0; miss = 0; inval = 0;
  endtask

  task automatic do_miss(input int d, input int s, input int ew, input int ee);
    miss_t m;
    m.w = ew; m.e = ee;
    mq[d].push_back(m);
    @(negedge clk); set = 2'(s); miss = 1; en[d] = 1;
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic do_hit(input int d, input int s, input int w, input int exp_err);
    if (exp_err != 0) pend_err[d]++;
    @(negedge clk); set = 2'(s); way = 2'(w); hit = 1; en[d] = 1;
    @(negedge clk); idle();
  endtask

  task automatic do_inval(input int d, input int s, input int w);
    @(negedge clk); set = 2'(s); way = 2'(w); inval = 1; en[d] = 1;
    @(negedge clk); idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pend_err[0] = 0; pend_err[1] = 0;
    rstn = 0; set = 0; way = 0; idle();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_done", int'(done[d]), 0);
      chk("rst_way", int'(wayo[d]), 0);
      chk("rst_ev", int'(ev[d]), 0);
      chk("rst_err", int'(err[d]), 0);
    end
    @(negedge clk); #2 rstn = 1;
    #1 chk("init_done_low", int'(done[0]), 0);
    @(posedge clk); #1;
    chk("init_done_lru", int'(done[0]), 1);
    chk("init_done_fifo", int'(done[1]), 1);

    // Fill and evict, set 2
    for (int w = 0; w < 4; w++) do_miss(0, 2, w, 0);
    do_miss(0, 2, 0, 1);

    // LRU promotion, set 0
    for (int w = 0; w < 4; w++) do_miss(0, 0, w, 0);
    do_hit(0, 0, 0, 0);
    do_miss(0, 0, 1, 1);
    do_hit(0, 0, 1, 0);
    do_miss(0, 0, 2, 1);

    // FIFO: same sequence, hits leave ages alone
    for (int w = 0; w < 4; w++) do_miss(1, 0, w, 0);
    do_hit(1, 0, 0, 0);
    do_miss(1, 0, 0, 1);
    do_hit(1, 0, 1, 0);
    do_miss(1, 0, 1, 1);

    // Invalidate in set 1, set 3 untouched
    do_miss(0, 3, 0, 0);
    for (int w = 0; w < 4; w++) do_miss(0, 1, w, 0);
    do_inval(0, 1, 2);
    do_hit(0, 1, 2, 1);
    do_hit(0, 1, 3, 0);
    do_miss(0, 1, 2, 0);
    do_miss(0, 1, 0, 1);
    do_miss(0, 3, 1, 0);

    // Priority: all strobes together -> invalidate only
    @(negedge clk); set = 0; way = 3; hit = 1; miss = 1; inval = 1; en[0] = 1;
    @(negedge clk); idle();
    chk("prio_done_high", int'(done[0]), 1);
    // Gated strobes (enable low) do nothing
    @(negedge clk); set = 0; way = 3; miss = 1; hit = 1; inval = 1;
    @(negedge clk); idle();
    // Strobes held during the fill cycle are ignored
    begin
      miss_t m;
      m.w = 3; m.e = 0; mq[0].push_back(m);
    end
    @(negedge clk); set = 0; miss = 1; en[0] = 1;
    @(negedge clk); way = 0; inval = 1; hit = 1;
    @(negedge clk); idle();
    do_miss(0, 0, 0, 1);

    // Async reset while done_o is low
    begin
      miss_t m;
      m.w = 1; m.e = 1; mq[0].push_back(m);
    end
    @(negedge clk); set = 2; miss = 1; en[0] = 1;
    @(negedge clk); idle();
    #1 rstn = 0;
    #1;
    chk("arst_done", int'(done[0]), 0);
    chk("arst_way", int'(wayo[0]), 0);
    chk("arst_ev", int'(ev[0]), 0);
    @(negedge clk);
    @(negedge clk); #2 rstn = 1;
    #1 chk("rel_done_low", int'(done[0]), 0);
    @(posedge clk); #1 chk("rel_done_high", int'(done[0]), 1);
    do_miss(0, 2, 0, 0);
    do_miss(0, 0, 0, 0);
    do_miss(1, 0, 0, 0);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pending_miss%0d", d), mq[d].size(), 0);
      chk($sformatf("pending_err%0d", d), pend_err[d], 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
